// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default byte width and a small modular-increment helper.
package uart_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam int DATA_WIDTH_DEF = 8;

  // Next index in a ring of n entries, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake and transmitter-side control bundle of the
// UART transmit arbiter. The slave modport is the arbiter's view; the
// master modport is the view of the requesters plus the transmitter.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          cfg_parity_enable;
  logic                          cfg_parity_type;
  logic [DATA_WIDTH-1:0]         tx_p_data;
  logic                          tx_data_valid;
  logic                          tx_parity_enable;
  logic                          tx_parity_type;
  logic                          tx_busy;

  modport slave (
    input  req_valid, req_data, cfg_parity_enable, cfg_parity_type, tx_busy,
    output req_ready, tx_p_data, tx_data_valid, tx_parity_enable, tx_parity_type
  );

  modport master (
    output req_valid, req_data, cfg_parity_enable, cfg_parity_type, tx_busy,
    input  req_ready, tx_p_data, tx_data_valid, tx_parity_enable, tx_parity_type
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, searching upward and wrapping from NUM_REQ-1 to 0.
module rr_select
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    sel,
  output logic [NUM_REQ-1:0] grant,
  output logic               any_valid
);

  int   idx;
  logic found;

  // Walk the ring once starting at rr_ptr and latch the first hit.
  always_comb begin
    sel   = '0;
    grant = '0;
    found = 1'b0;
    idx   = int'(rr_ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && ((req >> idx) & NUM_REQ'(1)) != '0) begin
        found = 1'b1;
        sel   = ID_W'(idx);
        grant = NUM_REQ'(1) << idx;
      end
      idx = wrap_inc(idx, NUM_REQ);
    end
    any_valid = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
// requesters. Optional busy-rise watchdog enabled by UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_W       = 2
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int BUSY_TIMEOUT = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  uart_tx_arbiter_if.slave  bus,
  output logic [ID_W-1:0]   grant_id,
  output logic              arb_busy
`ifdef UART_ARB_TIMEOUT_EN
  , output logic            timeout_err
`endif
);

  logic [1:0]            state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  pen_q, pen_d;
  logic                  ptype_q, ptype_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       sel;
  logic [NUM_REQ-1:0]    grant_oh;
  logic                  any_valid;
  logic                  grant_ok;
  logic [ID_W-1:0]       next_ptr;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;
`endif

  rr_select #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_select (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .sel       (sel),
    .grant     (grant_oh),
    .any_valid (any_valid)
  );

  // Grant only in IDLE with the transmitter quiet; gating by RST keeps
  // req_ready low for the whole time reset is asserted.
  always_comb begin
    grant_ok      = RST && (state_q == IDLE) && !bus.tx_busy && any_valid;
    bus.req_ready = grant_ok ? grant_oh : '0;
    next_ptr      = ID_W'(wrap_inc(int'(grant_q), NUM_REQ));
  end

  // Next-state logic: capture on accept, pulse, wait for busy rise then fall.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    pen_d    = pen_q;
    ptype_d  = ptype_q;
    grant_d  = grant_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    to_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          data_d  = DATA_WIDTH'(bus.req_data >> (int'(sel) * DATA_WIDTH));
          pen_d   = bus.cfg_parity_enable;
          ptype_d = bus.cfg_parity_type;
          grant_d = sel;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
          to_d     = 1'b1;
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transmitter-facing registers; reset clears every output.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      data_q   <= '0;
      pen_q    <= 1'b0;
      ptype_q  <= 1'b0;
      grant_q  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      pen_q    <= pen_d;
      ptype_q  <= ptype_d;
      grant_q  <= grant_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      to_q     <= to_d;
`endif
    end
  end

  // Output mapping; Data_Valid is high exactly while in LAUNCH.
  always_comb begin
    bus.tx_p_data        = data_q;
    bus.tx_parity_enable = pen_q;
    bus.tx_parity_type   = ptype_q;
    bus.tx_data_valid    = (state_q == LAUNCH);
    grant_id             = grant_q;
    arb_busy             = (state_q != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
    timeout_err          = to_q;
`endif
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a simple transmitter model.
// Build with UART_ARB_TIMEOUT_EN to also exercise the busy-rise watchdog.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int BT = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();
  logic [IW-1:0] grant_id;
  logic          arb_busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ID_W(IW)
`ifdef UART_ARB_TIMEOUT_EN
    , .BUSY_TIMEOUT(BT)
`endif
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .grant_id (grant_id),
    .arb_busy (arb_busy)
`ifdef UART_ARB_TIMEOUT_EN
    , .timeout_err (timeout_err)
`endif
  );

  // Stimulus
  logic [NR-1:0]    rv = 4'hF;
  logic [NR*DW-1:0] rd = {8'h13, 8'h12, 8'h11, 8'h10};
  logic             pen = 1'b0;
  logic             ptype = 1'b0;
  logic             force_low = 1'b0;
  int               mode = 1;  // 0: clear on accept, 1: keep valid, 2: random

  assign bus.req_valid         = rv;
  assign bus.req_data          = rd;
  assign bus.cfg_parity_enable = pen;
  assign bus.cfg_parity_type   = ptype;

  // Transmitter model: busy rises the edge after Data_Valid, stays high
  // for a random frame length, then falls.
  logic txb;
  int   txcnt;
  assign bus.tx_busy = txb;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      txb   <= 1'b0;
      txcnt <= 0;
    end else if (txb) begin
      if (txcnt <= 1) txb <= 1'b0;
      else txcnt <= txcnt - 1;
    end else if (bus.tx_data_valid && !force_low) begin
      txb   <= 1'b1;
      txcnt <= $urandom_range(1, 10);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state (transaction level)
  bit            owned = 0, launch_nx = 0, seen = 0, exp_to = 0;
  int            m_ptr = 0, wb = 0, exp_id = 0, dut_to = 0;
  logic [DW-1:0] exp_data;
  bit            exp_pen, exp_pt;
  logic [NR-1:0] acc;
  int            gq[$];
  bit            lq[$];

  function automatic int pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (p + k) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic step();
    logic [NR-1:0] er;
    int s;
    @(negedge CLK);
    acc = '0;
    if (!RST) begin
      check_eq("rst_outputs", {bus.req_ready, bus.tx_p_data, bus.tx_data_valid,
               bus.tx_parity_enable, bus.tx_parity_type, grant_id, arb_busy}, 0);
`ifdef UART_ARB_TIMEOUT_EN
      check_eq("rst_timeout_err", timeout_err, 0);
`endif
      owned = 0; launch_nx = 0; seen = 0; m_ptr = 0; exp_to = 0;
    end else begin
      er = '0;
      s  = -1;
      if (!owned && !bus.tx_busy && rv != '0) begin
        s = pick(rv, m_ptr);
        er[s] = 1'b1;
      end
      check_eq("req_ready", bus.req_ready, er);
      check_eq("arb_busy", arb_busy, owned);
      check_eq("data_valid", bus.tx_data_valid, launch_nx);
`ifdef UART_ARB_TIMEOUT_EN
      check_eq("timeout_err", timeout_err, exp_to);
      if (timeout_err) dut_to++;
`endif
      exp_to = 0;
      if (owned) begin
        check_eq("p_data", bus.tx_p_data, exp_data);
        check_eq("parity", {bus.tx_parity_enable, bus.tx_parity_type}, {exp_pen, exp_pt});
        check_eq("grant_id", grant_id, exp_id);
      end
      if (er != '0) begin
        acc = er; owned = 1; launch_nx = 1; seen = 0; wb = 0;
        exp_id = s; exp_data = rd[s*DW +: DW]; exp_pen = pen; exp_pt = ptype;
        gq.push_back(s);
      end else if (owned) begin
        if (launch_nx) begin
          launch_nx = 0;
          lq.push_back(bus.tx_parity_type);
        end else if (!seen) begin
          if (bus.tx_busy) seen = 1;
          else begin
`ifdef UART_ARB_TIMEOUT_EN
            if (wb == BT - 1) begin
              owned = 0; m_ptr = (exp_id + 1) % NR; exp_to = 1;
            end
`endif
            wb++;
          end
        end else if (!bus.tx_busy) begin
          owned = 0;
          m_ptr = (exp_id + 1) % NR;
        end
      end
    end
    @(posedge CLK);
    #1;
    if (mode == 0) rv = rv & ~acc;
    else if (mode == 2) begin
      rv = rv & ~acc;
      for (int i = 0; i < NR; i++) begin
        if (!rv[i] && $urandom_range(0, 3) == 0) begin
          rv[i] = 1'b1;
          rd[i*DW +: DW] = 8'($urandom);
        end else if (rv[i] && $urandom_range(0, 31) == 0) begin
          rv[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 7) == 0) pen = ~pen;
      if ($urandom_range(0, 7) == 0) ptype = ~ptype;
    end
  endtask

  task automatic run_until_idle(input string tag, input int max);
    int n = 0;
    do begin step(); n++; end while (owned && n < max);
    check_eq(tag, owned, 0);
  endtask

  task automatic run_until_seen(input string tag, input int max);
    int n = 0;
    do begin step(); n++; end while (!(owned && seen) && n < max);
    check_eq(tag, owned && seen, 1);
  endtask

  task automatic async_reset_check();
    #2 RST = 1'b0;
    #1 check_eq("rst_async", {bus.req_ready, bus.tx_p_data, bus.tx_data_valid,
                bus.tx_parity_enable, bus.tx_parity_type, grant_id, arb_busy}, 0);
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset with every requester valid, then fairness 0,1,2,3,0
    repeat (3) step();
    RST = 1'b1;
    begin
      int n = 0;
      while (gq.size() < 5 && n < 300) begin step(); n++; end
    end
    check_eq("fair_count", gq.size() >= 5, 1);
    for (int i = 0; i < 5 && i < gq.size(); i++) check_eq("fair_order", gq[i], exp_order[i]);
    mode = 0;
    rv = '0;
    run_until_idle("drain1", 100);

    // Single request from 2, parity type changed mid-frame
    gq.delete(); lq.delete();
    rd[2*DW +: DW] = 8'hA5; pen = 1'b1; ptype = 1'b0; rv = 4'b0100;
    run_until_seen("single_busy", 50);
    ptype = 1'b1;
    run_until_idle("single_done", 100);
    rd[0 +: DW] = 8'h3C; rv = 4'b0001;
    run_until_idle("cfg_next_done", 100);
    check_eq("single_gid", gq.size() > 0 ? gq[0] : -1, 2);
    check_eq("next_gid", gq.size() > 1 ? gq[1] : -1, 0);
    check_eq("par_frame0", lq.size() > 0 ? lq[0] : 1'bx, 0);
    check_eq("par_frame1", lq.size() > 1 ? lq[1] : 1'bx, 1);

    // Requester 1 withdraws before its turn; requester 3 must win
    gq.delete();
    rd[0 +: DW] = 8'h5A; rv = 4'b0001;
    step();
    rd[1*DW +: DW] = 8'h77; rd[3*DW +: DW] = 8'h99; rv = rv | 4'b1010;
    step();
    rv[1] = 1'b0;
    run_until_idle("wd_first", 100);
    run_until_idle("wd_second", 100);
    check_eq("wd_gid", gq.size() > 1 ? gq[1] : -1, 3);

    // Reset while waiting for busy to fall, then grant from rr_ptr=0
    gq.delete();
    rd[2*DW +: DW] = 8'hC3; rv = 4'b0100;
    run_until_seen("rst_frame", 50);
    async_reset_check();
    rd[1*DW +: DW] = 8'h44; rv = 4'b0110;
    repeat (2) step();
    RST = 1'b1;
    run_until_idle("post_rst", 100);
    check_eq("post_rst_gid", gq.size() > 0 ? gq[gq.size()-1] : -1, 1);

    // Randomized traffic
    mode = 2;
    repeat (2500) step();
    mode = 0;
    rv = '0;
    run_until_idle("drain_rand", 100);

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter never goes busy: watchdog returns the FSM to IDLE
    force_low = 1'b1;
    dut_to = 0;
    rv = 4'b0001;
    run_until_idle("to_idle", 100);
    repeat (2) step();
    check_eq("to_pulses", dut_to, 1);
    force_low = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation did not terminate");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART_TX transmitter among NUM_REQ byte requesters using round-robin arbitration. It accepts a byte from the granted requester through a valid/ready handshake. It then launches the byte into the transmitter with a one-cycle Data_Valid pulse and holds P_DATA and the parity configuration stable until the transmitter's busy falls. It sits between the system's byte producers and the UART_TX instance, and drives all of that instance's control inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width; must match the transmitter's P_DATA
ID_W, 2, width of grant_id; must be at least clog2(NUM_REQ)
BUSY_TIMEOUT, 16, cycles allowed for tx_busy to rise after launch (optional feature only)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte-available flag
req_data  in  NUM_REQ*DATA_WIDTH  per-requester byte; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot accept strobe; transfer occurs when valid and ready are both high
cfg_parity_enable  in  1  parity enable, sampled at accept
cfg_parity_type  in  1  parity type (0 even, 1 odd), sampled at accept
tx_p_data  out  DATA_WIDTH  to transmitter P_DATA
tx_data_valid  out  1  to transmitter Data_Valid
tx_parity_enable  out  1  to transmitter parity_enable
tx_parity_type  out  1  to transmitter parity_type
tx_busy  in  1  from transmitter busy
grant_id  out  ID_W  index of the requester currently owning the transmitter
arb_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0. All outputs 0: req_ready, tx_p_data, tx_data_valid, tx_parity_*, grant_id, arb_busy.
- Reset mid-frame returns the block to IDLE. Any latched byte is discarded and no req_ready is issued.
- The transmitter's CLK and RST are the same signals as this block's.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any req_valid is high and tx_busy=0, select the first valid index at or after rr_ptr, searching upward with wrap past NUM_REQ-1 to 0.
  - req_ready[sel] is asserted combinationally in the same cycle, and is the only req_ready bit asserted.
  - On that edge, register tx_p_data<=req_data[sel], tx_parity_enable<=cfg_parity_enable, tx_parity_type<=cfg_parity_type, grant_id<=sel. Go to LAUNCH.
  - If tx_busy=1 in IDLE (e.g. after an external reset skew), no grant is made.
- LAUNCH: tx_data_valid=1 for exactly this one cycle. Go to WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0, then go to IDLE and set rr_ptr<=(grant_id+1) mod NUM_REQ.
- tx_p_data, tx_parity_*, and grant_id are held constant from LAUNCH through WAIT_DONE. Outside IDLE, req_ready is all-zero.
- Requesters must hold req_valid and req_data until accepted. Dropping req_valid before accept is legal and has no side effect.
- Latency: accept at edge N; tx_data_valid is high in cycle N+1.
- Minimum spacing between accepts is the frame duration plus 3 cycles.
- Fairness: with all requesters valid, grants cycle 0,1,2,3,0,...
- Configuration change mid-frame has no effect until the next accept.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - Adds output timeout_err (1 bit, reset 0) and a counter that is cleared on entry to WAIT_BUSY.
  - If tx_busy stays 0 for BUSY_TIMEOUT cycles in WAIT_BUSY, pulse timeout_err for 1 cycle, go to IDLE, and advance rr_ptr as on normal completion.
- Undefined: no port and no counter; WAIT_BUSY waits indefinitely.

Decomposition:
- Shared package uart_pkg: FSM state encoding localparams (IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3) and the DATA_WIDTH default.
- One sub-module, rr_select: combinational round-robin picker. Inputs are the request vector and rr_ptr; outputs are sel index, one-hot grant, and any-valid.

Test Plan:
- Single request: req_valid[2]=1, req_data[2]=8'hA5, parity_enable=1, type=0. Expect req_ready[2] for 1 cycle, tx_data_valid 1 cycle later with tx_p_data=8'hA5 and parity bit 0 on TX_OUT. grant_id=2 until busy falls.
- All four valid with data 8'h10..8'h13: grant order 0,1,2,3,0. Each frame's tx_p_data is stable throughout busy; no two req_ready bits are ever high together.
- Config change: parity_type toggled from 0 to 1 mid-frame. The current frame's parity is unchanged; the next frame uses odd parity.
- Reset asserted in WAIT_DONE: all outputs 0 immediately. After release, a pending request is granted starting from rr_ptr=0.
- Requester 1 withdraws req_valid before its turn while requester 3 is valid: requester 3 is granted and requester 1 receives no ready.
- With UART_ARB_TIMEOUT_EN and tx_busy forced low: timeout_err pulses 16 cycles after entering WAIT_BUSY, and the FSM returns to IDLE.
